// File: rtl/ecall_service_sequencer.sv
// ecall_service_sequencer
// Services environment calls flagged by decode. It latches a7/a0, stalls the
// CPU, and drives the seven-segment value or LEDs, or samples the switches.
// It then waits for a debounced confirm press and release. READ_INT results
// are written back to a0. Exit halts the core until reset.
//
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_ecall_req        decode holds an ECALL (level)
//   i_a7, i_a0         service number / argument from register file
//   i_sw_in            synchronised board switches
//   i_confirm          synchronised, undebounced confirm button
//   o_cpu_stall        freeze PC and pipeline
//   o_reg_we           one-cycle write strobe to a0
//   o_reg_wdata        write data for a0
//   o_seg_value        seven-segment value
//   o_led_out          LED outputs
//   o_halted           core halted by exit service
//   o_svc_done         one-cycle pulse when a service retires
module ecall_service_sequencer #(
    parameter int          DEBOUNCE       = 2,
    parameter logic [31:0] SVC_PRINT_INT  = 32'd1,
    parameter logic [31:0] SVC_READ_INT   = 32'd5,
    parameter logic [31:0] SVC_EXIT       = 32'd10,
    parameter logic [31:0] SVC_PRINT_CHAR = 32'd11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ecall_req,
    input  logic [31:0] i_a7,
    input  logic [31:0] i_a0,
    input  logic [15:0] i_sw_in,
    input  logic        i_confirm,
    output logic        o_cpu_stall,
    output logic        o_reg_we,
    output logic [31:0] o_reg_wdata,
    output logic [31:0] o_seg_value,
    output logic [15:0] o_led_out,
    output logic        o_halted,
    output logic        o_svc_done
);

    localparam logic [7:0] DB = 8'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        DISPATCH     = 3'd1,
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        WRITEBACK    = 3'd4,
        RESUME       = 3'd5,
        HALT         = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a7;
    logic [31:0] r_a0;
    logic [7:0]  r_cnt;
    logic        r_guard;
    logic [31:0] r_rdata;
    logic [31:0] r_seg;
    logic [15:0] r_led;

    logic        w_start;
    logic        w_cnt_hit;
    logic        w_is_read;

    // Guard blocks a stale ECALL still present in decode the cycle after RESUME.
    assign w_start   = i_ecall_req && !r_guard;
    // The count is compared from the register, so the transition happens one
    // cycle after the DEBOUNCE-th qualifying sample.
    assign w_cnt_hit = (r_cnt == DB);
    assign w_is_read = (r_a7 == SVC_READ_INT);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = DISPATCH;
            DISPATCH: begin
                if (r_a7 == SVC_PRINT_INT || r_a7 == SVC_PRINT_CHAR || r_a7 == SVC_READ_INT)
                    w_next = WAIT_PRESS;
                else if (r_a7 == SVC_EXIT)
                    w_next = HALT;
                else
                    w_next = RESUME;
            end
            WAIT_PRESS:   if (w_cnt_hit) w_next = WAIT_RELEASE;
            WAIT_RELEASE: if (w_cnt_hit) w_next = w_is_read ? WRITEBACK : RESUME;
            WRITEBACK:    w_next = RESUME;
            RESUME:       w_next = IDLE;
            HALT:         w_next = HALT;
            default:      w_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        o_cpu_stall = 1'b0;
        o_reg_we    = 1'b0;
        o_halted    = 1'b0;
        o_svc_done  = 1'b0;
        case (r_state)
            IDLE:         o_cpu_stall = w_start;
            DISPATCH,
            WAIT_PRESS,
            WAIT_RELEASE: o_cpu_stall = 1'b1;
            WRITEBACK: begin
                o_cpu_stall = 1'b1;
                o_reg_we    = 1'b1;
            end
            RESUME:       o_svc_done  = 1'b1;
            HALT: begin
                o_cpu_stall = 1'b1;
                o_halted    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_reg_wdata = r_rdata;
    assign o_seg_value = r_seg;
    assign o_led_out   = r_led;

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a7    <= '0;
            r_a0    <= '0;
            r_guard <= 1'b0;
            r_rdata <= '0;
            r_seg   <= '0;
            r_led   <= '0;
        end else begin
            r_guard <= (r_state == RESUME);
            if (r_state == IDLE && w_start) begin
                r_a7 <= i_a7;
                r_a0 <= i_a0;
            end
            if (r_state == DISPATCH) begin
                if (r_a7 == SVC_PRINT_INT)  r_seg <= r_a0;
                if (r_a7 == SVC_PRINT_CHAR) r_led <= {8'h00, r_a0[7:0]};
            end
            // Switch sample is taken in the cycle the press is accepted.
            if (r_state == WAIT_PRESS && w_cnt_hit && w_is_read)
                r_rdata <= {{16{i_sw_in[15]}}, i_sw_in};
        end
    end

    // Debounce counter: counts consecutive high samples in WAIT_PRESS and
    // consecutive low samples in WAIT_RELEASE. It clears on a broken run and
    // on the accepting transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                WAIT_PRESS:   r_cnt <= w_cnt_hit ? 8'd0 : (i_confirm  ? r_cnt + 8'd1 : 8'd0);
                WAIT_RELEASE: r_cnt <= w_cnt_hit ? 8'd0 : (!i_confirm ? r_cnt + 8'd1 : 8'd0);
                default:      r_cnt <= 8'd0;
            endcase
        end
    end

endmodule

// File: doc/ecall_service_sequencer.md
# ecall_service_sequencer

Sequences environment-call service after the decode stage flags an ECALL. Decodes the service number in a7 and stalls the CPU. Drives the board display or LEDs, or samples the switches, then waits for a debounced user confirm. For read services it writes the result back to a0, then releases the pipeline; exit halts the core permanently until reset.

## Interface
Parameters:
- DEBOUNCE, 2, consecutive cycles confirm must be high to count as a press (legal 1..255)
- SVC_PRINT_INT, 1, a7 code: show a0 on seven-segment value
- SVC_READ_INT, 5, a7 code: read signed switches into a0
- SVC_EXIT, 10, a7 code: halt
- SVC_PRINT_CHAR, 11, a7 code: show a0[7:0] on LEDs

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ecall_req  in  1  decode stage holds an ECALL this cycle (level, stays high while stalled)
- a7  in  32  service number from register file
- a0  in  32  argument from register file
- sw_in  in  16  board switches, already synchronised
- confirm  in  1  confirm button, synchronised, not debounced
- cpu_stall  out  1  freeze PC and pipeline
- reg_we  out  1  one-cycle write strobe to x10 (a0)
- reg_wdata  out  32  write data for a0
- seg_value  out  32  value for seven-segment driver
- led_out  out  16  LED outputs
- halted  out  1  core halted by exit service
- svc_done  out  1  one-cycle pulse when a service retires

## Operation
- States: IDLE, DISPATCH, WAIT_PRESS, WAIT_RELEASE, WRITEBACK, RESUME, HALT.
- IDLE: on ecall_req go to DISPATCH; latch a7 and a0 into internal registers.
- DISPATCH, decoding the latched a7:
  - PRINT_INT: load seg_value with latched a0, then go to WAIT_PRESS.
  - PRINT_CHAR: load led_out[7:0] with a0[7:0] and clear led_out[15:8], then go to WAIT_PRESS.
  - READ_INT: go to WAIT_PRESS.
  - EXIT: go to HALT.
  - Any other code: go to RESUME. This is a no-op ecall.
- WAIT_PRESS:
  - An 8-bit counter counts consecutive high samples of confirm.
  - The counter clears on any low sample.
  - When the count reaches DEBOUNCE, go to WAIT_RELEASE.
  - For READ_INT, capture sw_in sign-extended to 32 bits in that same cycle.
- WAIT_RELEASE: wait for confirm low for DEBOUNCE consecutive cycles. Then go to WRITEBACK if READ_INT, else RESUME. This prevents one press retiring two back-to-back ecalls.
- WRITEBACK: reg_we=1, reg_wdata=captured value; next state RESUME.
- RESUME: svc_done=1 and cpu_stall=0, so the decode stage advances past the ECALL; next state IDLE. In IDLE, ecall_req is ignored for the first cycle after RESUME: a one-cycle guard bit blocks re-triggering on stale decode.
- HALT: terminal. cpu_stall=1, halted=1, all inputs ignored; only rst_n exits.
- seg_value and led_out hold their last value across services. READ_INT does not alter them.

## Timing
- Reset (async, rst_n low): state=IDLE, cpu_stall=0, reg_we=0, reg_wdata=0, seg_value=0, led_out=0, halted=0, svc_done=0, debounce counter=0, guard=0.
- cpu_stall = ecall_req combinationally in IDLE (guard clear). It is 1 in DISPATCH, WAIT_PRESS, WAIT_RELEASE, WRITEBACK and HALT, and 0 in RESUME. The ECALL is therefore frozen in the same cycle it is decoded.
- Latency, ecall_req to svc_done with no confirm: unknown code 3 cycles (IDLE, DISPATCH, RESUME).
- Latency with confirm: for PRINT/READ, svc_done asserts 2·DEBOUNCE+2 cycles (+1 for WRITEBACK) after the press edge, with an ideal press/release.
- seg_value/led_out update on the clock edge leaving DISPATCH.
- reg_we is high for exactly one cycle. RESUME follows on the next cycle.
- confirm already high when WAIT_PRESS is entered still counts. WAIT_RELEASE guarantees a fresh press per service.
- A confirm glitch shorter than DEBOUNCE resets the counter and is not a press. The same applies to a short low during release.
- rst_n asserted mid-service aborts immediately: there is no writeback, and outputs take reset values.
- ecall_req dropping during a service (flush) does not abort. The service completes.

## Test plan
- Reset: rst_n low mid-WAIT_PRESS with seg_value=0x1234 -> all outputs 0 asynchronously, state IDLE after release.
- PRINT_INT: a7=1, a0=0xDEADBEEF, confirm high 2 cycles then low 2 cycles (DEBOUNCE=2) -> seg_value=0xDEADBEEF, stall held until release, reg_we never high, one svc_done pulse.
- READ_INT: a7=5, sw_in=0x8005, press and release -> reg_we one cycle with reg_wdata=0xFFFF8005; a second run with sw_in=0x007F -> 0x0000007F.
- Debounce: a7=11, a0=0x141, confirm pulses of 1 cycle repeated -> stays in WAIT_PRESS, led_out=0x0041; a 2-cycle press then retires.
- EXIT: a7=10 -> halted=1 and cpu_stall=1 two cycles after ecall_req. Both remain under further confirm/ecall_req activity until rst_n.
- Unknown a7=99 -> svc_done 2 cycles after ecall_req with no confirm needed. A held ecall_req in the following cycle is blocked by the guard, and the next ecall_req after that starts a new service.
